pad_conditioner: RTL and testbench
==================================

Name: pad_conditioner

Overview:
- Upstream stage of the controller multiplexer (multitap).
- Takes the raw per-player button words from the host input path, applies 3-button masking, SOCD (opposing-direction) cleaning and frame-synchronous turbo.
- Optionally latches results once per frame.
- Drives the P1..P5 button inputs of the multiplexer as registered, active-high "pressed" signals.

Parameters:
- NPLAYERS, 5, number of player slots processed.
- TURBO_HALF, 2, frames per turbo half-period (turbo rate = 60/(2*TURBO_HALF) Hz on NTSC); legal 1..15.
- FRAME_LATCH, 0, 1 = outputs update only on VBLANK rising edge; 0 = continuous.

Ports:
- CLK  in  1  system clock.
- RESET_N  in  1  synchronous reset, active low.
- JOY  in  12*NPLAYERS  raw buttons, active high; slot n at [12n+11:12n].
  - Bit order: 0 RIGHT, 1 LEFT, 2 DOWN, 3 UP, 4 A, 5 B, 6 C, 7 START, 8 MODE, 9 X, 10 Y, 11 Z.
- TURBO  in  6*NPLAYERS  per-player turbo enable for A,B,C,X,Y,Z (bits 0..5), slot n at [6n+5:6n].
- SOCD_MODE  in  2  0 pass-through, 1 neutral, 2 last-input-wins, 3 treated as 0.
- J3BUT  in  1  3-button pad mode.
- VBLANK  in  1  video vertical blank level, synchronous to CLK.
- P_OUT  out  12*NPLAYERS  conditioned buttons, same packing as JOY.
- TURBO_PHASE  out  1  current turbo phase (1 = turbo buttons pass), for debug/OSD.

Behaviour:
- Reset (RESET_N=0 at a CLK edge):
  - P_OUT=0, TURBO_PHASE=1, frame counter=0.
  - All SOCD winner registers = NONE.
  - VBLANK edge detector register = 0.
  - Reset mid-frame discards any pending latch.
- Pipeline:
  - Stage 1 registers JOY, TURBO, SOCD_MODE, J3BUT.
  - Stage 2 computes the conditioned word and registers it into P_OUT.
  - Latency JOY -> P_OUT = 2 CLK with FRAME_LATCH=0.
- VBLANK edge: vbl_rise = VBLANK & ~vbl_q, where vbl_q is VBLANK registered every cycle.
- Turbo:
  - Frame counter 4 bits, increments on each vbl_rise.
  - When counter == TURBO_HALF-1 on a vbl_rise: counter wraps to 0 and TURBO_PHASE toggles.
  - For each of A,B,C,X,Y,Z: out = held & (~turbo_en | TURBO_PHASE).
  - TURBO_PHASE is global to all players.
  - Non-turbo buttons and directions are unaffected.
- 3-button: J3BUT=1 forces MODE,X,Y,Z outputs to 0, applied after turbo.
- SOCD, evaluated independently per player and per axis (LEFT/RIGHT, UP/DOWN):
  - Mode 0: raw.
  - Mode 1: both held -> both 0; otherwise raw.
  - Mode 2: per-axis winner register {NONE, NEG, POS}, updated each cycle from stage-1 data and previous stage-1 data. Rules in priority order:
    1. Neither held -> NONE.
    2. Only one held -> that one.
    3. Both held, exactly one newly pressed this cycle -> the new one.
    4. Both held, both newly pressed same cycle -> NONE (outputs neutral).
    5. Both held, neither new -> keep previous winner.
  - Output = the winner direction only.
  - Switching SOCD_MODE at runtime clears all winners to NONE on the next cycle.
- Frame latch (FRAME_LATCH=1):
  - Stage-2 result loads into P_OUT only on cycles where vbl_rise=1; otherwise P_OUT holds.
  - Turbo phase toggle and latch on the same vbl_rise: the latched value uses the new phase.
- Slots whose JOY bits are all 0 produce P_OUT=0 (no special casing).

Decomposition:
- Shared package pad_pkg:
  - Bit-index constants (BTN_RIGHT..BTN_Z).
  - Width constant PAD_W=12.
  - Enum socd_win_t {NONE, NEG, POS}.
  - Enum socd_mode_t.
- One sub-module, socd_axis: a single axis winner register and its output logic, instantiated 2*NPLAYERS times.
- Turbo counter and VBLANK edge logic stay in the top module.

Test Plan:
- Reset: hold RESET_N=0 for 3 clk with JOY all 1s -> P_OUT=0, TURBO_PHASE=1. Release -> P_OUT[11:0]=12'hFFF on the 2nd clk after release (SOCD_MODE=0, J3BUT=0).
- Turbo: slot0 A held, TURBO[0]=1, TURBO_HALF=2, 8 vbl pulses -> P_OUT[4] sequence per frame 1,1,0,0,1,1,0,0. B held without turbo stays 1 throughout.
- SOCD neutral: mode 1, slot2 LEFT+RIGHT+UP -> P_OUT[25:24]=00, P_OUT[27]=1. Release LEFT -> RIGHT=1 two clk later.
- SOCD last-wins:
  - Mode 2, slot1 RIGHT held, then LEFT pressed -> output LEFT only.
  - Release LEFT -> RIGHT.
  - Press both in the same cycle from idle -> both 0.
  - Switch mode to 0 -> both 1 two clk later.
- 3-button: J3BUT=1, JOY slot4 = 12'hF00 -> P_OUT[59:48]=0. J3BUT=0 -> 12'hF00.
- Frame latch (FRAME_LATCH=1): change JOY mid-frame -> P_OUT unchanged until the clk after the VBLANK rising edge, then reflects the new value. Assert RESET_N=0 mid-frame -> P_OUT=0 immediately and stays 0 until the next vbl_rise after release.

Source files
------------

// File: rtl/pad_pkg.sv
// Shared definitions for the pad conditioner: button bit positions, widths,
// SOCD enums and the last-input-wins winner rule.
package pad_pkg;

  localparam int PAD_W   = 12;
  localparam int TURBO_W = 6;

  localparam int BTN_RIGHT = 0;
  localparam int BTN_LEFT  = 1;
  localparam int BTN_DOWN  = 2;
  localparam int BTN_UP    = 3;
  localparam int BTN_A     = 4;
  localparam int BTN_B     = 5;
  localparam int BTN_C     = 6;
  localparam int BTN_START = 7;
  localparam int BTN_MODE  = 8;
  localparam int BTN_X     = 9;
  localparam int BTN_Y     = 10;
  localparam int BTN_Z     = 11;

  // Buttons that do not exist on a 3-button pad (MODE, X, Y, Z)
  localparam logic [PAD_W-1:0] J3_MASK = 12'hF00;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    NEG  = 2'd1,
    POS  = 2'd2
  } socd_win_t;

  typedef enum logic [1:0] {
    SOCD_PASS    = 2'd0,
    SOCD_NEUTRAL = 2'd1,
    SOCD_LAST    = 2'd2,
    SOCD_RSVD    = 2'd3
  } socd_mode_t;

  function automatic socd_win_t socd_next(input logic neg, input logic pos,
                                          input logic neg_new, input logic pos_new,
                                          input socd_win_t prev);
    socd_win_t w;
    if (!neg && !pos)             w = NONE;
    else if (neg && !pos)         w = NEG;
    else if (pos && !neg)         w = POS;
    else if (neg_new && !pos_new) w = NEG;
    else if (pos_new && !neg_new) w = POS;
    else if (neg_new && pos_new)  w = NONE;
    else                          w = prev;
    return w;
  endfunction

endpackage

// File: rtl/pad_conditioner_if.sv
// Button bus between the host input path and the pad conditioner.
interface pad_conditioner_if
  import pad_pkg::*;
#(
  parameter int NPLAYERS = 5
);
  logic [PAD_W*NPLAYERS-1:0]   joy;
  logic [TURBO_W*NPLAYERS-1:0] turbo;
  logic [1:0]                  socd_mode;
  logic                        j3but;
  logic                        vblank;
  logic [PAD_W*NPLAYERS-1:0]   p_out;
  logic                        turbo_phase;

  modport master (output joy, turbo, socd_mode, j3but, vblank,
                  input  p_out, turbo_phase);
  modport slave  (input  joy, turbo, socd_mode, j3but, vblank,
                  output p_out, turbo_phase);
endinterface

// File: rtl/socd_axis.sv
// One SOCD axis (LEFT/RIGHT or UP/DOWN): winner register and cleaned outputs.
module socd_axis
  import pad_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  socd_mode_t mode,
  input  logic       mode_chg,
  input  logic       neg,
  input  logic       pos,
  input  logic       neg_prev,
  input  logic       pos_prev,
  output logic       neg_out,
  output logic       pos_out
);

  socd_win_t win_r;
  socd_win_t win_next_s;

  // Next winner; the output uses it directly so last-wins adds no latency
  always_comb begin
    if (mode_chg) begin
      win_next_s = NONE;
    end else begin
      win_next_s = socd_next(neg, pos, neg & ~neg_prev, pos & ~pos_prev, win_r);
    end
  end

  // Winner register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      win_r <= NONE;
    end else begin
      win_r <= win_next_s;
    end
  end

  // Cleaned direction outputs per mode
  always_comb begin
    neg_out = neg;
    pos_out = pos;
    case (mode)
      SOCD_NEUTRAL: begin
        neg_out = neg & ~pos;
        pos_out = pos & ~neg;
      end
      SOCD_LAST: begin
        neg_out = (win_next_s == NEG);
        pos_out = (win_next_s == POS);
      end
      default: begin
        neg_out = neg;
        pos_out = pos;
      end
    endcase
  end

endmodule

// File: rtl/pad_conditioner.sv
// Per-player button conditioning (SOCD, turbo, 3-button mask) ahead of the
// multitap, with optional once-per-frame output latching.
module pad_conditioner
  import pad_pkg::*;
#(
  parameter int NPLAYERS    = 5,
  parameter int TURBO_HALF  = 2,
  parameter bit FRAME_LATCH = 1'b0
)
(
  input  logic             clk,
  input  logic             reset_n,
  pad_conditioner_if.slave bus
);

  localparam int         JW      = PAD_W * NPLAYERS;
  localparam int         TW      = TURBO_W * NPLAYERS;
  localparam logic [3:0] HALF_M1 = 4'(TURBO_HALF - 1);

  logic [JW-1:0]       joy_r;
  logic [JW-1:0]       joy_prev_r;
  logic [TW-1:0]       turbo_r;
  socd_mode_t          mode_r;
  socd_mode_t          mode_prev_r;
  logic                j3_r;
  logic                mode_chg_s;
  logic [NPLAYERS-1:0] left_s;
  logic [NPLAYERS-1:0] right_s;
  logic [NPLAYERS-1:0] up_s;
  logic [NPLAYERS-1:0] down_s;
  logic [JW-1:0]       cond_s;
  logic [PAD_W-1:0]    w_s;
  logic [TURBO_W-1:0]  te_s;
  logic                vbl_q_r;
  logic                vbl_rise_s;
  logic [3:0]          cnt_r;
  logic [3:0]          cnt_next_s;
  logic                phase_r;
  logic                phase_next_s;
  logic [JW-1:0]       p_out_r;

  // Stage 1 input registers, plus the previous stage-1 word for edge detection
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      joy_r       <= '0;
      joy_prev_r  <= '0;
      turbo_r     <= '0;
      mode_r      <= SOCD_PASS;
      mode_prev_r <= SOCD_PASS;
      j3_r        <= 1'b0;
    end else begin
      joy_r       <= bus.joy;
      joy_prev_r  <= joy_r;
      turbo_r     <= bus.turbo;
      mode_r      <= socd_mode_t'(bus.socd_mode);
      mode_prev_r <= mode_r;
      j3_r        <= bus.j3but;
    end
  end

  assign mode_chg_s = (mode_r != mode_prev_r);

  for (genvar p = 0; p < NPLAYERS; p++) begin : g_player
    socd_axis u_lr (
      .clk      (clk),
      .reset_n  (reset_n),
      .mode     (mode_r),
      .mode_chg (mode_chg_s),
      .neg      (joy_r[p*PAD_W + BTN_LEFT]),
      .pos      (joy_r[p*PAD_W + BTN_RIGHT]),
      .neg_prev (joy_prev_r[p*PAD_W + BTN_LEFT]),
      .pos_prev (joy_prev_r[p*PAD_W + BTN_RIGHT]),
      .neg_out  (left_s[p]),
      .pos_out  (right_s[p])
    );
    socd_axis u_ud (
      .clk      (clk),
      .reset_n  (reset_n),
      .mode     (mode_r),
      .mode_chg (mode_chg_s),
      .neg      (joy_r[p*PAD_W + BTN_UP]),
      .pos      (joy_r[p*PAD_W + BTN_DOWN]),
      .neg_prev (joy_prev_r[p*PAD_W + BTN_UP]),
      .pos_prev (joy_prev_r[p*PAD_W + BTN_DOWN]),
      .neg_out  (up_s[p]),
      .pos_out  (down_s[p])
    );
  end

  // Frame counter and turbo phase; the new phase is visible on the rise cycle
  always_comb begin
    vbl_rise_s   = bus.vblank & ~vbl_q_r;
    cnt_next_s   = cnt_r;
    phase_next_s = phase_r;
    if (vbl_rise_s) begin
      if (cnt_r == HALF_M1) begin
        cnt_next_s   = 4'd0;
        phase_next_s = ~phase_r;
      end else begin
        cnt_next_s   = cnt_r + 4'd1;
      end
    end else begin
      cnt_next_s = cnt_r;
    end
  end

  // Stage 2 word: SOCD directions, turbo gating, then 3-button mask
  always_comb begin
    cond_s = '0;
    w_s    = '0;
    te_s   = '0;
    for (int p = 0; p < NPLAYERS; p++) begin
      w_s  = joy_r[p*PAD_W +: PAD_W];
      te_s = turbo_r[p*TURBO_W +: TURBO_W];
      w_s[BTN_RIGHT] = right_s[p];
      w_s[BTN_LEFT]  = left_s[p];
      w_s[BTN_DOWN]  = down_s[p];
      w_s[BTN_UP]    = up_s[p];
      w_s[BTN_A]     = w_s[BTN_A] & (~te_s[0] | phase_next_s);
      w_s[BTN_B]     = w_s[BTN_B] & (~te_s[1] | phase_next_s);
      w_s[BTN_C]     = w_s[BTN_C] & (~te_s[2] | phase_next_s);
      w_s[BTN_X]     = w_s[BTN_X] & (~te_s[3] | phase_next_s);
      w_s[BTN_Y]     = w_s[BTN_Y] & (~te_s[4] | phase_next_s);
      w_s[BTN_Z]     = w_s[BTN_Z] & (~te_s[5] | phase_next_s);
      w_s            = w_s & ~({PAD_W{j3_r}} & J3_MASK);
      cond_s[p*PAD_W +: PAD_W] = w_s;
    end
  end

  // Edge detector, turbo state and output register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      vbl_q_r <= 1'b0;
      cnt_r   <= 4'd0;
      phase_r <= 1'b1;
      p_out_r <= '0;
    end else begin
      vbl_q_r <= bus.vblank;
      cnt_r   <= cnt_next_s;
      phase_r <= phase_next_s;
      if (!FRAME_LATCH || vbl_rise_s) begin
        p_out_r <= cond_s;
      end
    end
  end

  assign bus.p_out       = p_out_r;
  assign bus.turbo_phase = phase_r;

endmodule

// File: tb/tb_pad_conditioner.sv
// Bench for pad_conditioner: a continuous and a frame-latched instance checked
// every cycle against a behavioural model, plus directed literal checks.
module tb_pad_conditioner;

  localparam int NP = 5;
  localparam int TH = 2;
  localparam int W  = 12 * NP;
  localparam int TW = 6 * NP;

  logic          clk;
  logic          reset_n;
  logic [W-1:0]  joy;
  logic [TW-1:0] turbo;
  logic [1:0]    socd_mode;
  logic          j3but;
  logic          vblank;

  int n_cmp = 0;
  int n_bad = 0;

  pad_conditioner_if #(.NPLAYERS(NP)) if0 ();
  pad_conditioner_if #(.NPLAYERS(NP)) if1 ();

  assign if0.joy = joy;   assign if0.turbo = turbo; assign if0.socd_mode = socd_mode;
  assign if0.j3but = j3but; assign if0.vblank = vblank;
  assign if1.joy = joy;   assign if1.turbo = turbo; assign if1.socd_mode = socd_mode;
  assign if1.j3but = j3but; assign if1.vblank = vblank;

  pad_conditioner #(.NPLAYERS(NP), .TURBO_HALF(TH), .FRAME_LATCH(1'b0)) dut0 (
    .clk(clk), .reset_n(reset_n), .bus(if0));
  pad_conditioner #(.NPLAYERS(NP), .TURBO_HALF(TH), .FRAME_LATCH(1'b1)) dut1 (
    .clk(clk), .reset_n(reset_n), .bus(if1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- behavioural model ----------------
  logic [W-1:0]  s1_joy, s1p_joy;
  logic [TW-1:0] s1_turbo;
  logic [1:0]    s1_mode, s1p_mode;
  logic          s1_j3;
  logic          vbl_prev;
  int            rises;
  int            win [NP][2];   // 0 none, 1 negative dir, 2 positive dir
  logic [W-1:0]  exp0, exp1;
  logic          exp_ph;
  bit            model_valid = 1'b0;
  int            turbo_btn [6] = '{4, 5, 6, 9, 10, 11};

  initial begin
    logic [W-1:0]  nxt;
    logic [11:0]   w, wp;
    logic          rise, n, q, nn, pn;
    int            nb, pb, md;
    forever begin
      @(posedge clk);
      if (!reset_n) begin
        model_valid = 1'b1;
        s1_joy = '0; s1p_joy = '0; s1_turbo = '0; s1_mode = 2'd0; s1p_mode = 2'd0;
        s1_j3 = 1'b0; vbl_prev = 1'b0; rises = 0; exp0 = '0; exp1 = '0; exp_ph = 1'b1;
        for (int p = 0; p < NP; p++) begin win[p][0] = 0; win[p][1] = 0; end
      end else begin
        rise = vblank && !vbl_prev;
        if (rise) rises++;
        exp_ph = ((rises / TH) % 2) == 0;
        md = (s1_mode == 2'd3) ? 0 : int'(s1_mode);
        nxt = '0;
        for (int p = 0; p < NP; p++) begin
          w  = s1_joy[p*12 +: 12];
          wp = s1p_joy[p*12 +: 12];
          for (int ax = 0; ax < 2; ax++) begin
            nb = (ax == 0) ? 1 : 3;   // LEFT / UP
            pb = (ax == 0) ? 0 : 2;   // RIGHT / DOWN
            n = w[nb]; q = w[pb]; nn = n && !wp[nb]; pn = q && !wp[pb];
            if (s1_mode != s1p_mode)  win[p][ax] = 0;
            else if (!n && !q)        win[p][ax] = 0;
            else if (n && !q)         win[p][ax] = 1;
            else if (q && !n)         win[p][ax] = 2;
            else if (nn && !pn)       win[p][ax] = 1;
            else if (pn && !nn)       win[p][ax] = 2;
            else if (nn && pn)        win[p][ax] = 0;
            if (md == 1) begin
              w[nb] = n && !q; w[pb] = q && !n;
            end else if (md == 2) begin
              w[nb] = (win[p][ax] == 1); w[pb] = (win[p][ax] == 2);
            end
          end
          for (int k = 0; k < 6; k++)
            if (s1_turbo[p*6 + k] && !exp_ph) w[turbo_btn[k]] = 1'b0;
          if (s1_j3) w[11:8] = 4'h0;
          nxt[p*12 +: 12] = w;
        end
        exp0 = nxt;
        if (rise) exp1 = nxt;
        vbl_prev = vblank;
        s1p_joy = s1_joy; s1p_mode = s1_mode;
        s1_joy = joy; s1_turbo = turbo; s1_mode = socd_mode; s1_j3 = j3but;
      end
      #1;
      if (model_valid) begin
        check("p_out_cont",  if0.p_out, exp0);
        check("p_out_latch", if1.p_out, exp1);
        check("phase_cont",  if0.turbo_phase, exp_ph);
        check("phase_latch", if1.turbo_phase, exp_ph);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  bit           tseq [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
  logic [W-1:0] v1, v2;

  initial begin
    reset_n = 1'b0; joy = '1; turbo = '0; socd_mode = 2'd0; j3but = 1'b0; vblank = 1'b0;
    v1 = 60'h0FE_DCB_A98_765_432;
    v2 = 60'h123_456_789_ABC_DEF;

    // Reset with all buttons pressed
    step(3);
    check("rst_pout", if0.p_out, 64'h0);
    check("rst_phase", if0.turbo_phase, 64'h1);
    reset_n = 1'b1;
    step(2);
    check("rst_release_slot0", if0.p_out[11:0], 64'hFFF);
    check("rst_release_latch", if1.p_out, 64'h0);

    // Turbo on A of slot 0, B held without turbo
    joy = '0; joy[11:0] = 12'h030; turbo = '0; turbo[0] = 1'b1;
    step(3);
    for (int f = 0; f < 8; f++) begin
      check("turbo_a", if0.p_out[4], 64'(tseq[f]));
      check("turbo_b", if0.p_out[5], 64'h1);
      vblank = 1'b1; step(1);
      vblank = 1'b0; step(3);
    end
    turbo = '0;

    // SOCD neutral, slot 2
    socd_mode = 2'd1; joy = '0; joy[35:24] = 12'h00B;
    step(3);
    check("neutral_lr", if0.p_out[25:24], 64'h0);
    check("neutral_up", if0.p_out[27], 64'h1);
    joy[35:24] = 12'h009;
    step(2);
    check("neutral_rel", if0.p_out[24], 64'h1);

    // SOCD last-input-wins, slot 1
    socd_mode = 2'd2; joy = '0;
    step(3);
    joy[12] = 1'b1;          step(3);
    joy[13] = 1'b1;          step(3);
    check("last_left", if0.p_out[13:12], 64'h2);
    joy[13] = 1'b0;          step(3);
    check("last_right", if0.p_out[13:12], 64'h1);
    joy[13:12] = 2'b00;      step(2);
    joy[13:12] = 2'b11;      step(3);
    check("last_both", if0.p_out[13:12], 64'h0);
    socd_mode = 2'd0;        step(2);
    check("last_to_raw", if0.p_out[13:12], 64'h3);

    // 3-button mask, slot 4
    joy = '0; joy[59:48] = 12'hF00; j3but = 1'b1;
    step(3);
    check("j3_on", if0.p_out[59:48], 64'h0);
    j3but = 1'b0;
    step(2);
    check("j3_off", if0.p_out[59:48], 64'hF00);

    // Frame latch
    joy = v1; step(3);
    vblank = 1'b1; step(1);
    check("latch_v1", if1.p_out, 64'(v1));
    vblank = 1'b0; joy = v2; step(3);
    check("latch_hold", if1.p_out, 64'(v1));
    vblank = 1'b1; step(1);
    check("latch_v2", if1.p_out, 64'(v2));
    vblank = 1'b0; step(2);
    reset_n = 1'b0; step(1);
    check("latch_rst", if1.p_out, 64'h0);
    reset_n = 1'b1; step(3);
    check("latch_rst_hold", if1.p_out, 64'h0);
    vblank = 1'b1; step(1);
    check("latch_after_rst", if1.p_out, 64'(v2));
    vblank = 1'b0; step(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
